// File: rtl/shift_register_universal.sv
// shift_register_universal
// Universal WIDTH-bit shift register: hold, shift right, shift left and
// parallel load, with a registered serial output per direction and a shift
// counter that strobes o_word_done on every WIDTH-th shift.
//
// Optional feature macro: SHREG_ROTATE_EN
//   When defined, port i_rot exists. While shifting with i_rot=1, the bit
//   leaving the far end is fed back in place of the serial input.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   i_clr        synchronous clear (wins over any operation)
//   i_en         operation enable; i_mode ignored when low
//   i_mode       00 hold, 01 shift right, 10 shift left, 11 parallel load
//   i_sin_r      serial bit entering q[WIDTH-1] on shift right
//   i_sin_l      serial bit entering q[0] on shift left
//   i_pdata_in   parallel load data
//   i_rot        rotate select (SHREG_ROTATE_EN only)
//   o_q          register contents
//   o_sout_r     registered bit shifted out of q[0]
//   o_sout_l     registered bit shifted out of q[WIDTH-1]
//   o_count      shifts since last load/clear/wrap
//   o_word_done  one-cycle strobe on the WIDTH-th shift
module shift_register_universal #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic             i_sin_r,
  input  logic             i_sin_l,
  input  logic [WIDTH-1:0] i_pdata_in,
`ifdef SHREG_ROTATE_EN
  input  logic             i_rot,
`endif
  output logic [WIDTH-1:0] o_q,
  output logic             o_sout_r,
  output logic             o_sout_l,
  output logic [CW-1:0]    o_count,
  output logic             o_word_done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic             r_sout_r;
  logic             r_sout_l;
  logic [CW-1:0]    r_count;
  logic             r_word_done;

  logic             w_fill_r;
  logic             w_fill_l;
  logic             w_last;
  logic [CW-1:0]    w_count_nxt;

  // Bit entering each end on a shift: serial input, or the opposite end when rotating
`ifdef SHREG_ROTATE_EN
  assign w_fill_r = i_rot ? r_q[0]       : i_sin_r;
  assign w_fill_l = i_rot ? r_q[WIDTH-1] : i_sin_l;
`else
  assign w_fill_r = i_sin_r;
  assign w_fill_l = i_sin_l;
`endif

  // Shift counter wraps on the WIDTH-th shift regardless of direction
  assign w_last      = (r_count == CW'(WIDTH - 1));
  assign w_count_nxt = w_last ? '0 : r_count + CW'(1);

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q         <= '0;
      r_sout_r    <= 1'b0;
      r_sout_l    <= 1'b0;
      r_count     <= '0;
      r_word_done <= 1'b0;
    end else if (i_clr) begin
      r_q         <= '0;
      r_sout_r    <= 1'b0;
      r_sout_l    <= 1'b0;
      r_count     <= '0;
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= 1'b0;
      if (i_en) begin
        case (i_mode)
          MODE_HOLD: begin
          end
          MODE_RIGHT: begin
            r_q         <= {w_fill_r, r_q[WIDTH-1:1]};
            r_sout_r    <= r_q[0];
            r_count     <= w_count_nxt;
            r_word_done <= w_last;
          end
          MODE_LEFT: begin
            r_q         <= {r_q[WIDTH-2:0], w_fill_l};
            r_sout_l    <= r_q[WIDTH-1];
            r_count     <= w_count_nxt;
            r_word_done <= w_last;
          end
          MODE_LOAD: begin
            r_q     <= i_pdata_in;
            r_count <= '0;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_q         = r_q;
  assign o_sout_r    = r_sout_r;
  assign o_sout_l    = r_sout_l;
  assign o_count     = r_count;
  assign o_word_done = r_word_done;

endmodule

// File: doc/shift_register_universal.md
# shift_register_universal

Parametrised universal shift register, WIDTH bits wide. Supports hold, shift-right, shift-left and parallel load. Each direction has a registered serial output. A shift counter pulses a word-done strobe after every WIDTH shifts. It generalises the team's fixed 4-bit right-shift SISO register and is the serialiser/deserialiser building block for the serial links in the design.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64
- CW, $clog2(WIDTH), counter width (localparam, not overridable)

- clk  input  1  clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- clr  input  1  synchronous clear, active-high
- en  input  1  operation enable; mode is ignored when low
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
- sin_r  input  1  serial bit entering q[WIDTH-1] on shift right
- sin_l  input  1  serial bit entering q[0] on shift left
- pdata_in  input  WIDTH  parallel load data
- rot  input  1  rotate select; exists only when SHREG_ROTATE_EN is defined
- q  output  WIDTH  register contents (parallel out)
- sout_r  output  1  registered bit shifted out of q[0]
- sout_l  output  1  registered bit shifted out of q[WIDTH-1]
- count  output  CW  shifts since last load/clear/wrap
- word_done  output  1  one-cycle strobe on the WIDTH-th shift

## Operation
- Priority per edge: rst > clr > (en && mode).
- rst (async) or clr (sync): q=0, sout_r=0, sout_l=0, count=0, word_done=0.
- en=0 or mode=00: q, sout_r, sout_l and count hold; word_done=0.
- mode=01, shift right: q <= {sin_r, q[WIDTH-1:1]}; sout_r <= old q[0]; sout_l holds.
- mode=10, shift left: q <= {q[WIDTH-2:0], sin_l}; sout_l <= old q[WIDTH-1]; sout_r holds.
- mode=11, parallel load: q <= pdata_in; count <= 0; word_done <= 0; sout_r and sout_l hold.
- Counter on every shift (01 or 10):
  - count != WIDTH-1: count <= count+1, word_done <= 0.
  - count == WIDTH-1: count <= 0 (wrap), word_done <= 1 for exactly one cycle.
- Mixed directions count identically; the counter does not track direction.
- Back-to-back shifts across a wrap: word_done is high for one cycle, then low on the next shift; count continues from 0.
- A load on the cycle after a wrap clears nothing further; word_done falls as normal.

## Timing
- All outputs are registered and update on the rising edge of clk where the operation is sampled. No combinational input-to-output paths.
- Latency is 1 cycle from control sampling to q/count/word_done. The shifted-out bit appears on sout_r/sout_l on the same edge that removes it from q.
- rst asserted mid-operation clears all state immediately, with no clock needed. Deassertion is synchronised externally. The first operation is sampled on the first rising edge with rst low.
- clr together with en=1 and any mode: the clear wins, and the shift or load is discarded.

## Configuration
- SHREG_ROTATE_EN defined:
  - Port rot exists.
  - While shifting with rot=1, the serial input is replaced by the bit leaving the opposite end: right q <= {q[0], q[WIDTH-1:1]}, left q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - sout_r/sout_l, count and word_done behave as for a normal shift.
  - rot is ignored for hold, load and clear.
- SHREG_ROTATE_EN undefined:
  - Port rot is absent.
  - Shifts always use sin_r/sin_l.
  - No rotate logic is synthesised.

## Test plan
- Reset mid-shift (WIDTH=8): load 0xFF, shift right 3 times, assert rst between edges. Required: q=0x00, count=0, sout_r=0, word_done=0 immediately, without a clock edge.
- Right serialise: load 0xA5, then 8 right shifts with sin_r=0.
  - sout_r sequence after each edge: 1,0,1,0,0,1,0,1.
  - count runs 1..7 then 0.
  - word_done is high only after the 8th edge; final q=0x00.
- Left shift/deserialise: load 0x81, 1 left shift with sin_l=1. Required: q=0x03, sout_l=1, count=1. Then 7 more left shifts with sin_l=0: q=0x80 and word_done pulses once.
- Priority and hold:
  - clr=1 with en=1, mode=11, pdata_in=0x5A: q=0x00.
  - en=0 with mode=01 for 4 cycles: q, count and serial outputs unchanged; word_done=0.
- Rotate (SHREG_ROTATE_EN defined): load 0x01, rot=1, one right shift: q=0x80, sout_r=1. Seven further rotate-right shifts: q=0x01 with a word_done pulse on the 8th shift. With rot=0 and sin_r=0, one right shift from 0x01 gives q=0x00.
